// File: rtl/mac_sequencer_pkg.sv
// Shared types and defaults for the MAC sequencer: FSM state encoding,
// default widths and the 2x2-bit product helper.
package mac_sequencer_pkg;

  localparam int unsigned LEN_W_DEF = 4;
  localparam int unsigned ACC_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_ACCUM  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_e;

  function automatic logic [3:0] mul2x2(input logic [1:0] a, input logic [1:0] b);
    return {2'b00, a} * {2'b00, b};
  endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Bundles the job request, operand stream, MAC control and result handshake.
// slave = sequencer side, master = requester/consumer/MAC side.
interface mac_sequencer_if #(
  parameter int unsigned LEN_W = 4,
  parameter int unsigned ACC_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             op_valid;
  logic             op_ready;
  logic [1:0]       op_a;
  logic [1:0]       op_b;
  logic [1:0]       mac_a;
  logic [1:0]       mac_b;
  logic [3:0]       mac_zero;
  logic             mac_en;
  logic             mac_clr;
  logic [ACC_W-1:0] mac_acc;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] result;
  logic             overflow;

  modport slave (
    input  start, len, op_valid, op_a, op_b, mac_acc, res_ready,
    output busy, op_ready, mac_a, mac_b, mac_zero, mac_en, mac_clr,
           res_valid, result, overflow
  );

  modport master (
    output start, len, op_valid, op_a, op_b, mac_acc, res_ready,
    input  busy, op_ready, mac_a, mac_b, mac_zero, mac_en, mac_clr,
           res_valid, result, overflow
  );
endinterface

// File: rtl/mac_seq_counter.sv
// Remaining-pairs down-counter: synchronous load, decrement, zero flag.
module mac_seq_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);
endmodule

// File: rtl/mac_sequencer.sv
// Sequences one dot-product job through the external MAC: clear, gated
// accumulate per accepted operand pair, then capture result and sticky overflow.
module mac_sequencer
  import mac_sequencer_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input logic            clk,
  input logic            reset,
  mac_sequencer_if.slave bus
);
  localparam int unsigned SUM_W = ACC_W + 1;

  seq_state_e       state_q, state_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] result_q, result_d;

  logic             cnt_load;
  logic             cnt_zero;
  logic [LEN_W-1:0] cnt;
  logic             op_ready;
  logic             hs;
  logic [3:0]       prod;
  logic [SUM_W-1:0] sum;

  mac_seq_counter #(.W(LEN_W)) u_counter (
    .clk       (clk),
    .reset     (reset),
    .load_i    (cnt_load),
    .load_val_i(bus.len),
    .dec_i     (hs),
    .count_o   (cnt),
    .zero_o    (cnt_zero)
  );

  assign op_ready = (state_q == ST_ACCUM) && !cnt_zero;
  assign hs       = bus.op_valid && op_ready;
  assign prod     = mul2x2(bus.op_a, bus.op_b);
  // Mirror of the MAC's next value one bit wider, so the carry flags the wrap.
  assign sum      = {1'b0, bus.mac_acc} + SUM_W'(prod);

  always_comb begin
    state_d  = state_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    cnt_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          cnt_load = 1'b1;
          ovf_d    = 1'b0;
          state_d  = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_d = cnt_zero ? ST_SETTLE : ST_ACCUM;
      end
      ST_ACCUM: begin
        if (hs) begin
          if (sum[ACC_W]) begin
            ovf_d = 1'b1;
          end
          if (cnt == LEN_W'(1)) begin
            state_d = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        result_d = bus.mac_acc;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.op_ready  = op_ready;
  assign bus.mac_a     = bus.op_a;
  assign bus.mac_b     = bus.op_b;
  assign bus.mac_zero  = '0;
  assign bus.mac_en    = hs;
  assign bus.mac_clr   = (state_q == ST_CLEAR);
  assign bus.res_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a behavioural MAC register in the harness.
module tb_mac_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_sequencer_if #(.LEN_W(4), .ACC_W(8)) bus ();

  mac_sequencer #(.LEN_W(4), .ACC_W(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt   = 0;
  int clr_cnt  = 0;
  int excl_viol = 0;
  int en0, clr0;
  logic [7:0] mac_q   = '0;
  logic [7:0] clr_val = '0;
  logic [1:0] pa [16];
  logic [1:0] pb [16];

  // Harness MAC: clear loads clr_val so a job can start from a preloaded sum.
  always @(posedge clk) begin
    if (bus.mac_clr) mac_q <= clr_val;
    else if (bus.mac_en) mac_q <= mac_q + 8'(bus.mac_a) * 8'(bus.mac_b);
  end
  assign bus.mac_acc = mac_q;

  always @(posedge clk) begin
    if (bus.mac_en)  en_cnt  <= en_cnt + 1;
    if (bus.mac_clr) clr_cnt <= clr_cnt + 1;
  end
  always @(negedge clk) begin
    if ((bus.mac_clr && bus.mac_en) || (bus.mac_en && !bus.op_ready)) excl_viol++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int l, input bit gap, input logic [7:0] exp_res,
                         input logic exp_ovf, input string tag);
    bus.len   = 4'(l);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq({tag, "_clr"}, 32'(bus.mac_clr), 1);
    check_eq({tag, "_busy"}, 32'(bus.busy), 1);
    tick();
    for (int i = 0; i < l; i++) begin
      if (gap && i > 0) begin
        bus.op_valid = 1'b0;
        #1;
        check_eq({tag, "_gap_rdy"}, 32'(bus.op_ready), 1);
        check_eq({tag, "_gap_en"}, 32'(bus.mac_en), 0);
        tick();
      end
      bus.op_valid = 1'b1;
      bus.op_a = pa[i];
      bus.op_b = pb[i];
      #1;
      check_eq({tag, "_en"}, 32'(bus.mac_en), 1);
      tick();
    end
    bus.op_valid = 1'b0;
    #1;
    check_eq({tag, "_settle_rv"}, 32'(bus.res_valid), 0);
    check_eq({tag, "_settle_rdy"}, 32'(bus.op_ready), 0);
    tick();
    check_eq({tag, "_rv"}, 32'(bus.res_valid), 1);
    check_eq({tag, "_res"}, 32'(bus.result), 32'(exp_res));
    check_eq({tag, "_ovf"}, 32'(bus.overflow), 32'(exp_ovf));
  endtask

  task automatic accept(input string tag);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check_eq({tag, "_idle"}, 32'(bus.busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.len = '0; bus.op_valid = 1'b0;
    bus.op_a = '0; bus.op_b = '0; bus.res_ready = 1'b0;
    #13;
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_rdy",  32'(bus.op_ready), 0);
    check_eq("rst_clr",  32'(bus.mac_clr), 0);
    check_eq("rst_rv",   32'(bus.res_valid), 0);
    check_eq("rst_ovf",  32'(bus.overflow), 0);
    check_eq("rst_res",  32'(bus.result), 0);
    check_eq("rst_zero", 32'(bus.mac_zero), 0);
    reset = 1'b0;
    tick();

    // 1: three distinct pairs, 9+2+1
    pa[0] = 2'd3; pb[0] = 2'd3; pa[1] = 2'd2; pb[1] = 2'd1; pa[2] = 2'd1; pb[2] = 2'd1;
    en0 = en_cnt; clr0 = clr_cnt;
    run_job(3, 1'b0, 8'd12, 1'b0, "t1");
    check_eq("t1_en_pulses", 32'(en_cnt - en0), 3);
    check_eq("t1_clr_pulses", 32'(clr_cnt - clr0), 1);
    accept("t1");

    // 2: empty job, consumer already ready on entry to DONE
    en0 = en_cnt;
    bus.res_ready = 1'b1;
    run_job(0, 1'b0, 8'd0, 1'b0, "t2");
    check_eq("t2_en_pulses", 32'(en_cnt - en0), 0);
    tick();
    bus.res_ready = 1'b0;
    check_eq("t2_idle", 32'(bus.busy), 0);

    // 3: 15 x (3,3) with gaps
    for (int i = 0; i < 16; i++) begin pa[i] = 2'd3; pb[i] = 2'd3; end
    run_job(15, 1'b1, 8'd135, 1'b0, "t3");
    accept("t3");

    // 4: two back-to-back full jobs, then one from a preloaded 200 that wraps
    run_job(15, 1'b0, 8'd135, 1'b0, "t4a");
    accept("t4a");
    run_job(15, 1'b0, 8'd135, 1'b0, "t4b");
    accept("t4b");
    clr_val = 8'd200;
    run_job(15, 1'b0, 8'd79, 1'b1, "t4c");
    clr_val = 8'd0;
    accept("t4c");

    // 5: asynchronous reset in the middle of ACCUM
    bus.len = 4'd5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.op_valid = 1'b1;
    tick();
    tick();
    check_eq("t5_busy_pre", 32'(bus.busy), 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("t5_busy", 32'(bus.busy), 0);
    check_eq("t5_rdy",  32'(bus.op_ready), 0);
    check_eq("t5_en",   32'(bus.mac_en), 0);
    check_eq("t5_clr",  32'(bus.mac_clr), 0);
    check_eq("t5_rv",   32'(bus.res_valid), 0);
    check_eq("t5_ovf",  32'(bus.overflow), 0);
    check_eq("t5_res",  32'(bus.result), 0);
    #1;
    reset = 1'b0;
    bus.op_valid = 1'b0;
    tick();
    check_eq("t5_idle", 32'(bus.busy), 0);
    pa[0] = 2'd2; pb[0] = 2'd2;
    run_job(1, 1'b0, 8'd4, 1'b0, "t5");
    accept("t5");

    // 6: hold in DONE, start must be ignored
    pa[0] = 2'd1; pb[0] = 2'd2;
    run_job(1, 1'b0, 8'd2, 1'b0, "t6");
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin bus.start = 1'b1; bus.len = 4'd7; end
      tick();
      bus.start = 1'b0;
      check_eq("t6_hold_rv", 32'(bus.res_valid), 1);
      check_eq("t6_hold_res", 32'(bus.result), 2);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check_eq("t6_idle", 32'(bus.busy), 0);
    check_eq("t6_rv_low", 32'(bus.res_valid), 0);
    tick();
    check_eq("t6_still_idle", 32'(bus.busy), 0);
    check_eq("t6_no_clr", 32'(bus.mac_clr), 0);

    check_eq("excl", 32'(excl_viol), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
